// File: rtl/lcd_frame_scanner.sv
// Raster scanner for a 240x320 ILI9341-style panel: sends the full-screen window command
// sequence, then streams one RGB565 word per pixel over an 8080 16-bit write bus.
module lcd_frame_scanner #(
    parameter int H_PIX   = 240,
    parameter int V_PIX   = 320,
    parameter int PIX_LAT = 1,
    parameter int WR_LOW  = 2,
    parameter int WR_HIGH = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        continuous,
    output logic        busy,
    output logic        frame_done,
    output logic [7:0]  xAddLCD,
    output logic [8:0]  yAddLCD,
    input  logic [15:0] pixelData,
    output logic        lcd_cs_n,
    output logic        lcd_rs,
    output logic        lcd_wr_n,
    output logic        lcd_rd_n,
    output logic [15:0] lcd_data
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CMD  = 2'd1;
    localparam logic [1:0] ST_PIX  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [1:0] PH_SETUP = 2'd0;
    localparam logic [1:0] PH_LOW   = 2'd1;
    localparam logic [1:0] PH_HIGH  = 2'd2;

    localparam logic [7:0]  SETUP_LAST = 8'(PIX_LAT - 1);
    localparam logic [7:0]  LOW_LAST   = 8'(WR_LOW - 1);
    localparam logic [7:0]  HIGH_LAST  = 8'(WR_HIGH - 1);
    localparam logic [7:0]  X_LAST     = 8'(H_PIX - 1);
    localparam logic [8:0]  Y_LAST     = 9'(V_PIX - 1);
    localparam logic [15:0] H_M1       = 16'(H_PIX - 1);
    localparam logic [15:0] V_M1       = 16'(V_PIX - 1);
    localparam logic [3:0]  WIDX_LAST  = 4'd10;

    logic [1:0]  state_q, state_d;
    logic [1:0]  phase_q, phase_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [3:0]  widx_q, widx_d;
    logic [7:0]  x_q, x_d;
    logic [8:0]  y_q, y_d;
    logic        rs_q, rs_d;
    logic [15:0] data_q, data_d;

    logic        phase_end;
    logic [15:0] cmd_word;
    logic        cmd_rs;

    always_comb begin
        case (phase_q)
            PH_SETUP: phase_end = (cnt_q == SETUP_LAST);
            PH_LOW:   phase_end = (cnt_q == LOW_LAST);
            default:  phase_end = (cnt_q == HIGH_LAST);
        endcase
    end

    // Window setup: column address set, page address set, then memory write.
    always_comb begin
        cmd_rs = 1'b1;
        case (widx_q)
            4'd0:    begin cmd_word = 16'h002A; cmd_rs = 1'b0; end
            4'd3:    cmd_word = {8'h00, H_M1[15:8]};
            4'd4:    cmd_word = {8'h00, H_M1[7:0]};
            4'd5:    begin cmd_word = 16'h002B; cmd_rs = 1'b0; end
            4'd8:    cmd_word = {8'h00, V_M1[15:8]};
            4'd9:    cmd_word = {8'h00, V_M1[7:0]};
            4'd10:   begin cmd_word = 16'h002C; cmd_rs = 1'b0; end
            default: cmd_word = 16'h0000;
        endcase
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        widx_d  = widx_q;
        x_d     = x_q;
        y_d     = y_q;
        rs_d    = rs_q;
        data_d  = data_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start || continuous) begin
                    state_d = ST_CMD;
                    phase_d = PH_SETUP;
                    cnt_d   = '0;
                    widx_d  = '0;
                end
            end
            ST_CMD, ST_PIX: begin
                if (!phase_end) begin
                    cnt_d = cnt_q + 8'd1;
                end else begin
                    cnt_d = '0;
                    case (phase_q)
                        PH_SETUP: begin
                            phase_d = PH_LOW;
                            if (state_q == ST_CMD) begin
                                data_d = cmd_word;
                                rs_d   = cmd_rs;
                            end else begin
                                data_d = pixelData;
                                rs_d   = 1'b1;
                            end
                        end
                        PH_LOW: phase_d = PH_HIGH;
                        default: begin
                            phase_d = PH_SETUP;
                            if (state_q == ST_CMD) begin
                                if (widx_q == WIDX_LAST) begin
                                    state_d = ST_PIX;
                                    widx_d  = '0;
                                end else begin
                                    widx_d = widx_q + 4'd1;
                                end
                            end else if (x_q == X_LAST) begin
                                x_d = '0;
                                if (y_q == Y_LAST) begin
                                    y_d     = '0;
                                    state_d = ST_DONE;
                                end else begin
                                    y_d = y_q + 9'd1;
                                end
                            end else begin
                                x_d = x_q + 8'd1;
                            end
                        end
                    endcase
                end
            end
            ST_DONE: begin
                state_d = continuous ? ST_CMD : ST_IDLE;
                phase_d = PH_SETUP;
                cnt_d   = '0;
                widx_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            phase_q <= PH_SETUP;
            cnt_q   <= '0;
            widx_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            rs_q    <= 1'b1;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            widx_q  <= widx_d;
            x_q     <= x_d;
            y_q     <= y_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
        end
    end

    // The synchronous pixel ROM registers the address on the slot boundary edge itself,
    // so it is fed the next-state address; its output is then valid after PIX_LAT setup clocks.
    assign xAddLCD    = x_d;
    assign yAddLCD    = y_d;
    assign busy       = (state_q != ST_IDLE);
    assign frame_done = (state_q == ST_DONE);
    assign lcd_cs_n   = !((state_q == ST_CMD) || (state_q == ST_PIX));
    assign lcd_wr_n   = !(((state_q == ST_CMD) || (state_q == ST_PIX)) && (phase_q == PH_LOW));
    assign lcd_rd_n   = 1'b1;
    assign lcd_rs     = rs_q;
    assign lcd_data   = data_q;

endmodule
